// File: rtl/kim_pkg.sv
// Shared constants for the KIM-1 display/keypad block: key matrix geometry, scan select codes
// and key indices, plus the lowest-index key priority encoder.
package kim_pkg;

  localparam int KIM_NUM_KEYS = 21;
  localparam int KIM_KEY_COLS = 7;

  localparam logic [3:0] SEL_ROW0   = 4'd0;
  localparam logic [3:0] SEL_ROW1   = 4'd1;
  localparam logic [3:0] SEL_ROW2   = 4'd2;
  localparam logic [3:0] SEL_DIGIT0 = 4'd4;

  localparam logic [4:0] KEY_NONE = 5'h1F;

  // Matrix index = row*7 + col; hex keys occupy 0..15, command keys follow in row 2.
  localparam logic [4:0] KEY_0    = 5'd0;
  localparam logic [4:0] KEY_1    = 5'd1;
  localparam logic [4:0] KEY_2    = 5'd2;
  localparam logic [4:0] KEY_3    = 5'd3;
  localparam logic [4:0] KEY_4    = 5'd4;
  localparam logic [4:0] KEY_5    = 5'd5;
  localparam logic [4:0] KEY_6    = 5'd6;
  localparam logic [4:0] KEY_7    = 5'd7;
  localparam logic [4:0] KEY_8    = 5'd8;
  localparam logic [4:0] KEY_9    = 5'd9;
  localparam logic [4:0] KEY_A    = 5'd10;
  localparam logic [4:0] KEY_B    = 5'd11;
  localparam logic [4:0] KEY_C    = 5'd12;
  localparam logic [4:0] KEY_D    = 5'd13;
  localparam logic [4:0] KEY_E    = 5'd14;
  localparam logic [4:0] KEY_F    = 5'd15;
  localparam logic [4:0] KEY_AD   = 5'd16;
  localparam logic [4:0] KEY_DA   = 5'd17;
  localparam logic [4:0] KEY_PLUS = 5'd18;
  localparam logic [4:0] KEY_GO   = 5'd19;
  localparam logic [4:0] KEY_PC   = 5'd20;

  function automatic logic [4:0] key_prio(input logic [KIM_NUM_KEYS-1:0] v);
    key_prio = KEY_NONE;
    for (int i = KIM_NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) key_prio = 5'(i);
  endfunction

endpackage

// File: rtl/kim_key_debounce.sv
// Key matrix synchronizer and optional debounce filter (enabled by KIMDK_DEBOUNCE_EN).
// keys_raw is asynchronous; keys_db is the stable vector the monitor ROM sees.
module kim_key_debounce
  import kim_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                    phi2,
  input  logic                    rst_n,
  input  logic [KIM_NUM_KEYS-1:0] keys_raw,
  output logic [KIM_NUM_KEYS-1:0] keys_db
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [KIM_NUM_KEYS-1:0] keys_s1, keys_sync;

  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      keys_s1   <= '0;
      keys_sync <= '0;
    end else begin
      keys_s1   <= keys_raw;
      keys_sync <= keys_s1;
    end
  end

`ifdef KIMDK_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [KIM_NUM_KEYS-1:0] keys_prev, keys_db_q;
  logic [DW-1:0]           dcnt;

  // A change wins over the terminal count so a one-cycle flip at the end of a
  // stable run can never be latched.
  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      keys_prev <= '0;
      keys_db_q <= '0;
      dcnt      <= '0;
    end else begin
      keys_prev <= keys_sync;
      if (keys_sync != keys_prev)
        dcnt <= '0;
      else if (dcnt == DW'(DEBOUNCE_CYCLES - 1))
        keys_db_q <= keys_sync;
      else
        dcnt <= dcnt + 1'b1;
    end
  end

  assign keys_db = keys_db_q;
`else
  assign keys_db = keys_sync;
`endif

endmodule

// File: rtl/kim_display_keypad.sv
// KIM-1 display/keypad consumer of the RRIOT port pins: scan decode, persistent 6-digit frame
// buffer, keypad readback on PAI. Debounce filtering is enabled by defining KIMDK_DEBOUNCE_EN.
module kim_display_keypad
  import kim_pkg::*;
#(
  parameter int NUM_DIGITS      = 6,
  parameter int PERSIST_CYCLES  = 4096,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                      phi2,
  input  logic                      rst_n,
  input  logic [7:0]                PAO,
  input  logic [7:0]                DDRA,
  input  logic [7:0]                PBO,
  input  logic [7:0]                DDRB,
  output logic [7:0]                PAI,
  input  logic [KIM_NUM_KEYS-1:0]   keys_raw,
  input  logic                      tty_rxd,
  output logic [7*NUM_DIGITS-1:0]   seg_out,
  output logic [NUM_DIGITS-1:0]     digit_lit,
  output logic                      key_any,
  output logic [4:0]                key_code
);

  localparam int PW = (PERSIST_CYCLES > 1) ? $clog2(PERSIST_CYCLES) : 1;

  // Undriven port bits float high through the board pull-ups.
  logic [7:0] pb_pin;
  logic [6:0] pa_seg;
  logic [3:0] sel;
  logic       unused_pb;

  assign pb_pin    = (PBO & DDRB) | ~DDRB;
  assign pa_seg    = (PAO[6:0] & DDRA[6:0]) | ~DDRA[6:0];
  assign sel       = pb_pin[4:1];
  assign unused_pb = ^{pb_pin[7:5], pb_pin[0]};

  logic [KIM_NUM_KEYS-1:0] keys_db;

  kim_key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .phi2     (phi2),
    .rst_n    (rst_n),
    .keys_raw (keys_raw),
    .keys_db  (keys_db)
  );

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam logic [3:0] MY_SEL = 4'(SEL_DIGIT0 + d);

    logic [6:0]    seg_q;
    logic          lit_q;
    logic [PW-1:0] pcnt;

    always_ff @(posedge phi2) begin
      if (!rst_n) begin
        seg_q <= '0;
        lit_q <= 1'b0;
        pcnt  <= '0;
      end else if (sel == MY_SEL) begin
        seg_q <= pa_seg;
        lit_q <= 1'b1;
        pcnt  <= PW'(PERSIST_CYCLES - 1);
      end else if (lit_q) begin
        if (pcnt <= PW'(1)) begin
          seg_q <= '0;
          lit_q <= 1'b0;
          pcnt  <= '0;
        end else begin
          pcnt <= pcnt - 1'b1;
        end
      end
    end

    assign seg_out[7*d +: 7] = seg_q;
    assign digit_lit[d]      = lit_q;
  end

  logic tty_s1, tty_sync;
  logic [6:0] row_n;

  always_comb begin
    row_n = 7'h7F;
    case (sel)
      SEL_ROW0: row_n = ~keys_db[0*KIM_KEY_COLS +: KIM_KEY_COLS];
      SEL_ROW1: row_n = ~keys_db[1*KIM_KEY_COLS +: KIM_KEY_COLS];
      SEL_ROW2: row_n = ~keys_db[2*KIM_KEY_COLS +: KIM_KEY_COLS];
      default:  row_n = 7'h7F;
    endcase
  end

  // Output-configured PA bits read back the RRIOT's own register, not the matrix.
  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      tty_s1   <= 1'b0;
      tty_sync <= 1'b0;
      PAI      <= 8'hFF;
      key_any  <= 1'b0;
      key_code <= KEY_NONE;
    end else begin
      tty_s1   <= tty_rxd;
      tty_sync <= tty_s1;
      PAI      <= ({tty_sync, row_n} & ~DDRA) | (PAO & DDRA);
      key_any  <= |keys_db;
      key_code <= key_prio(keys_db);
    end
  end

endmodule

// File: tb/tb_kim_display_keypad.sv
// Randomized bench for kim_display_keypad against a behavioural model of the scan/display/keypad rules.
module tb_kim_display_keypad;

  localparam int ND = 6;
  localparam int P  = 64;
  localparam int D  = 16;

  logic        phi2 = 1'b0;
  logic        rst_n;
  logic [7:0]  PAO, DDRA, PBO, DDRB, PAI;
  logic [20:0] keys_raw;
  logic        tty_rxd;
  logic [7*ND-1:0] seg_out;
  logic [ND-1:0]   digit_lit;
  logic        key_any;
  logic [4:0]  key_code;

  kim_display_keypad #(
    .NUM_DIGITS      (ND),
    .PERSIST_CYCLES  (P),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .phi2      (phi2),
    .rst_n     (rst_n),
    .PAO       (PAO),
    .DDRA      (DDRA),
    .PBO       (PBO),
    .DDRB      (DDRB),
    .PAI       (PAI),
    .keys_raw  (keys_raw),
    .tty_rxd   (tty_rxd),
    .seg_out   (seg_out),
    .digit_lit (digit_lit),
    .key_any   (key_any),
    .key_code  (key_code)
  );

  always #5 phi2 = ~phi2;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;

  // ---------------- behavioural model ----------------
  longint      cyc = 0;
  longint      last_ref [ND];
  bit          m_lit [ND];
  logic [6:0]  m_seg [ND];
  logic [7:0]  m_pai;
  bit          m_any;
  logic [4:0]  m_code;
  logic [20:0] m_s1, m_sync, m_db;
  logic        m_t1, m_tsync;
  logic [20:0] win [$];

  function automatic logic [4:0] lowest_key(input logic [20:0] v);
    for (int i = 0; i < 21; i++)
      if (v[i]) return 5'(i);
    return 5'h1F;
  endfunction

  always @(posedge phi2) begin : model
    logic [7:0] pa, pb;
    int         sel;
    logic [6:0] row;
    bit         same;
    if (!rst_n) begin
      m_pai = 8'hFF; m_any = 0; m_code = 5'h1F;
      m_s1 = '0; m_sync = '0; m_db = '0; m_t1 = 0; m_tsync = 0;
      for (int d = 0; d < ND; d++) begin m_lit[d] = 0; m_seg[d] = '0; last_ref[d] = 0; end
      win.delete();
      armed = 1;
    end else begin
      pa  = (PAO & DDRA) | ~DDRA;
      pb  = (PBO & DDRB) | ~DDRB;
      sel = int'(pb[4:1]);
      row = (sel <= 2) ? ~m_db[sel*7 +: 7] : 7'h7F;
      m_pai  = ({m_tsync, row} & ~DDRA) | (PAO & DDRA);
      m_any  = |m_db;
      m_code = lowest_key(m_db);
      for (int d = 0; d < ND; d++) begin
        if (sel == 4 + d) begin
          m_lit[d] = 1; m_seg[d] = pa[6:0]; last_ref[d] = cyc;
        end else if (m_lit[d] && (cyc - last_ref[d]) >= P - 1) begin
          m_lit[d] = 0; m_seg[d] = '0;
        end
      end
`ifdef KIMDK_DEBOUNCE_EN
      // keys_db follows the synchronized vector only after D+1 identical samples
      win.push_back(m_sync);
      if (win.size() > D + 1) void'(win.pop_front());
      if (win.size() == D + 1) begin
        same = 1;
        foreach (win[i]) if (win[i] != m_sync) same = 0;
        if (same) m_db = m_sync;
      end
`endif
      m_tsync = m_t1;   m_t1 = tty_rxd;
      m_sync  = m_s1;   m_s1 = keys_raw;
`ifndef KIMDK_DEBOUNCE_EN
      m_db = m_sync;
`endif
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge phi2) begin : compare
    logic [7*ND-1:0] e_seg;
    logic [ND-1:0]   e_lit;
    if (armed) begin
      for (int d = 0; d < ND; d++) begin
        e_seg[7*d +: 7] = m_seg[d];
        e_lit[d] = m_lit[d];
      end
      vectors++;
      if (PAI !== m_pai || seg_out !== e_seg || digit_lit !== e_lit ||
          key_any !== m_any || key_code !== m_code) begin
        miscompares++;
        $display("FAIL cycle %0d model: pai=%h/%h seg=%h/%h lit=%b/%b any=%b/%b code=%h/%h (dut/model)",
                 cyc, PAI, m_pai, seg_out, e_seg, digit_lit, e_lit, key_any, m_any, key_code, m_code);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge phi2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sel;
    bit idle;
    PAO = 8'h00; DDRA = 8'h00; PBO = 8'h00; DDRB = 8'h1E;
    keys_raw = '0; tty_rxd = 1'b1; rst_n = 1'b0;
    clk(3);
    chk("reset_pai", 64'(PAI), 64'hFF);
    chk("reset_seg", 64'(seg_out), 64'h0);
    chk("reset_code", 64'(key_code), 64'h1F);
    chk("reset_any", 64'(key_any), 64'h0);
    rst_n = 1'b1;

    // digit 0 capture
    PBO = 8'h08; DDRA = 8'h7F; PAO = 8'h3F;
    clk(10);
    chk("t1_seg0", 64'(seg_out[6:0]), 64'h3F);
    chk("t1_lit", 64'(digit_lit), 64'h01);

    // persistence expiry under sel 3
    PBO = 8'h06;
    clk(P - 2);
    chk("t2_lit_hold", 64'(digit_lit[0]), 64'h1);
    clk(1);
    chk("t2_lit_clear", 64'(digit_lit[0]), 64'h0);
    chk("t2_seg_clear", 64'(seg_out[6:0]), 64'h0);

    // key 9 (row 1, col 2)
    DDRA = 8'h00; PAO = 8'h00; keys_raw = 21'(1) << 9; PBO = 8'h02;
    clk(D + 10);
    chk("t3_pai_row1", 64'(PAI[6:0]), 64'h7B);
    chk("t3_code", 64'(key_code), 64'd9);
    chk("t3_any", 64'(key_any), 64'h1);
    PBO = 8'h00;
    clk(2);
    chk("t3_pai_row0", 64'(PAI[6:0]), 64'h7F);

`ifdef KIMDK_DEBOUNCE_EN
    keys_raw = '0;
    clk(D + 10);
    keys_raw = 21'h1;
    clk(D / 2);
    keys_raw = '0;
    clk(4);
    chk("t4_any_glitch", 64'(key_any), 64'h0);
    chk("t4_pai_glitch", 64'(PAI[6:0]), 64'h7F);
    clk(D + 10);
    chk("t4_any_after", 64'(key_any), 64'h0);
`endif

    keys_raw = (21'(1) << 3) | (21'(1) << 17);
    clk(D + 10);
    chk("t5_code_prio", 64'(key_code), 64'd3);
    DDRA = 8'h01; PAO = 8'h00; PBO = 8'h00; keys_raw = 21'h2;
    clk(D + 10);
    chk("t5_pai_readback", 64'(PAI[6:0]), 64'h7C);

    // tty latency and reset mid-scan
    DDRA = 8'h00; tty_rxd = 1'b0;
    clk(2);
    chk("t6_tty_early", 64'(PAI[7]), 64'h1);
    clk(1);
    chk("t6_tty", 64'(PAI[7]), 64'h0);
    tty_rxd = 1'b1;
    PBO = 8'h0A; DDRA = 8'h7F; PAO = 8'h06;
    clk(2);
    chk("t6_lit1", 64'(digit_lit), 64'h02);
    chk("t6_seg1", 64'(seg_out[13:7]), 64'h06);
    rst_n = 1'b0;
    clk(1);
    chk("t6_rst_seg", 64'(seg_out), 64'h0);
    chk("t6_rst_pai", 64'(PAI), 64'hFF);
    chk("t6_rst_code", 64'(key_code), 64'h1F);
    chk("t6_rst_lit", 64'(digit_lit), 64'h0);
    rst_n = 1'b1;
    clk(1);
    chk("t6_relight", 64'(digit_lit), 64'h02);
    chk("t6_reseg", 64'(seg_out[13:7]), 64'h06);

    // randomized scan traffic; idle phases let digits expire
    for (int i = 0; i < 3000; i++) begin
      idle = ((i / 200) % 2) == 1;
      if (idle) sel = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(10, 15);
      else      sel = $urandom_range(0, 15);
      DDRB = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h1E;
      PBO  = {3'($urandom), 4'(sel), 1'($urandom)};
      case ($urandom_range(0, 3))
        0: DDRA = 8'h00;
        1: DDRA = 8'h7F;
        default: DDRA = 8'($urandom);
      endcase
      PAO = 8'($urandom);
      if ($urandom_range(0, 31) == 0) keys_raw = 21'($urandom) & 21'($urandom) & 21'($urandom);
      if ($urandom_range(0, 7) == 0) tty_rxd = ~tty_rxd;
      rst_n = ($urandom_range(0, 599) != 0);
      clk(1);
    end
    rst_n = 1'b1;
    clk(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
